vcfg_ctrl: RTL and testbench

Vector configuration controller for the Carrd vector coprocessor. Accepts `vsetvli`, `vsetivli` and `vsetvl` instructions from the issue stage over a valid/ready handshake. Computes VLMAX and the new `vl` from AVL and the requested vtype, detects illegal vtype encodings, and drives the single-cycle write port of `vcsr` (`vconfig_wr_en`, `vl_in`, `vtype_in`). Also returns the new `vl` for scalar `rd` writeback.

---
 rtl/vcfg_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_vcfg_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcfg_ctrl.sv
// Vector configuration controller: decodes vsetvli/vsetivli/vsetvl, computes vl and drives the vcsr write port.
// Optional macro VCFG_FRAC_LMUL_EN makes the fractional LMUL encodings (mf2, mf4) legal.
module vcfg_ctrl #(
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] vl_cur,
    output logic        csr_wr_en,
    output logic [31:0] csr_vl,
    output logic [31:0] csr_vtype,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        cfg_done,
    output logic        vill
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic [6:0]  OPC_V  = 7'b1010111;
    localparam logic [31:0] VLEN_W = 32'(VLEN);
    localparam logic [31:0] ELEN_W = 32'(ELEN);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rs1_q, rs1_d;
    logic [10:0] rs2_q, rs2_d;

    logic        csr_wr_en_q, csr_wr_en_d;
    logic [31:0] csr_vl_q, csr_vl_d;
    logic [31:0] csr_vtype_q, csr_vtype_d;
    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        cfg_done_q, cfg_done_d;
    logic        vill_q, vill_d;

    logic        is_cfg;
    logic [10:0] vtype;
    logic [31:0] avl;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [2:0]  vsew;
    logic [2:0]  vlmul;
    logic [31:0] sew_bits;
    logic        lmul_ok;
    logic        legal;
    logic [31:0] vlmax;
    logic [31:0] vl;

    // Only vtype[10:0] of rs2 is architecturally meaningful.
    logic unused_rs2;
    assign unused_rs2 = ^rs2_data[31:11];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_cfg = 1'b0;
        vtype  = '0;
        rd_f   = instr_q[11:7];
        rs1_f  = instr_q[19:15];
        if (instr_q[6:0] == OPC_V && instr_q[14:12] == 3'b111) begin
            if (!instr_q[31]) begin
                is_cfg = 1'b1;
                vtype  = instr_q[30:20];
            end else if (instr_q[30]) begin
                is_cfg = 1'b1;
                vtype  = {1'b0, instr_q[29:20]};
            end else if (instr_q[29:25] == 5'd0) begin
                is_cfg = 1'b1;
                vtype  = rs2_q;
            end
        end

        // rs1 == x0 with rd != x0 requests VLMAX; with rd == x0 it keeps the current vl.
        if (instr_q[31:30] == 2'b11) begin
            avl = {27'd0, rs1_f};
        end else if (rs1_f != 5'd0) begin
            avl = rs1_q;
        end else if (rd_f != 5'd0) begin
            avl = 32'hFFFF_FFFF;
        end else begin
            avl = vl_cur;
        end
    end

    always_comb begin
        vsew     = vtype[5:3];
        vlmul    = vtype[2:0];
        sew_bits = 32'd8 << vsew;
`ifdef VCFG_FRAC_LMUL_EN
        // Fractional LMUL 1/2^k is legal only while SEW <= ELEN / 2^k.
        lmul_ok = !vlmul[2] ||
                  (vlmul != 3'd4 && sew_bits <= (ELEN_W >> (4'd8 - {1'b0, vlmul})));
`else
        lmul_ok = !vlmul[2];
`endif
        legal = (vsew <= 3'd2) && (sew_bits <= ELEN_W) && (vtype[10:8] == 3'd0) && lmul_ok;

        vlmax = (VLEN_W >> (4'd3 + {1'b0, vsew})) << vlmul;
`ifdef VCFG_FRAC_LMUL_EN
        if (vlmul[2]) begin
            vlmax = VLEN_W >> (5'd11 + {2'b00, vsew} - {2'b00, vlmul});
        end
`endif
        vl = (avl < vlmax) ? avl : vlmax;
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        csr_wr_en_d = 1'b0;
        csr_vl_d    = '0;
        csr_vtype_d = '0;
        rd_we_d     = 1'b0;
        rd_addr_d   = '0;
        rd_data_d   = '0;
        cfg_done_d  = 1'b0;
        vill_d      = vill_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    instr_d = cfg_instr;
                    rs1_d   = rs1_data;
                    rs2_d   = rs2_data[10:0];
                    state_d = CALC;
                end
            end
            CALC: begin
                // Results land in the output flops so they are stable for the whole COMMIT cycle.
                cfg_done_d = 1'b1;
                if (is_cfg) begin
                    csr_wr_en_d = 1'b1;
                    csr_vl_d    = legal ? vl : 32'd0;
                    csr_vtype_d = legal ? {1'b0, vtype, 20'd0} : 32'd0;
                    rd_we_d     = (rd_f != 5'd0);
                    rd_addr_d   = rd_f;
                    rd_data_d   = legal ? vl : 32'd0;
                    vill_d      = !legal;
                end
                state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            csr_wr_en_q <= 1'b0;
            csr_vl_q    <= '0;
            csr_vtype_q <= '0;
            rd_we_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            cfg_done_q  <= 1'b0;
            vill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            csr_wr_en_q <= csr_wr_en_d;
            csr_vl_q    <= csr_vl_d;
            csr_vtype_q <= csr_vtype_d;
            rd_we_q     <= rd_we_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            cfg_done_q  <= cfg_done_d;
            vill_q      <= vill_d;
        end
    end

    // NOTE: the captured operands need no reset; they are only read in CALC, after a fresh capture.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        rs1_q   <= rs1_d;
        rs2_q   <= rs2_d;
    end

    assign cfg_ready = nrst && (state_q == IDLE);
    assign csr_wr_en = csr_wr_en_q;
    assign csr_vl    = csr_vl_q;
    assign csr_vtype = csr_vtype_q;
    assign rd_we     = rd_we_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign cfg_done  = cfg_done_q;
    assign vill      = vill_q;

endmodule

// File: tb/tb_vcfg_ctrl.sv
// Self-checking bench for vcfg_ctrl: directed vsetvl* vectors, a transaction-level model checked every cycle.
// Build with VCFG_FRAC_LMUL_EN defined to exercise the fractional-LMUL expectations.
module tb_vcfg_ctrl;

    localparam int VLEN = 512;
    localparam int ELEN = 32;
    localparam logic [6:0] OPC_V = 7'b1010111;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] vl_cur;
    logic        csr_wr_en;
    logic [31:0] csr_vl;
    logic [31:0] csr_vtype;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        cfg_done;
    logic        vill;

    vcfg_ctrl #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_instr (cfg_instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .vl_cur    (vl_cur),
        .csr_wr_en (csr_wr_en),
        .csr_vl    (csr_vl),
        .csr_vtype (csr_vtype),
        .rd_we     (rd_we),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cfg_done  (cfg_done),
        .vill      (vill)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        cfg;
        logic        legal;
        logic [10:0] vtype;
        logic [31:0] vl;
        logic [4:0]  rd;
    } exp_t;

    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] r1,
                                     input logic [31:0] r2, input logic [31:0] vc);
        exp_t            e;
        logic [10:0]     vt;
        longint unsigned avl;
        longint unsigned vlmax;
        int              sew;
        int              lm;
        int              den;
        e    = '0;
        e.rd = ins[11:7];
        vt   = '0;
        if (ins[6:0] != OPC_V || ins[14:12] != 3'b111) return e;
        if (!ins[31])                vt = ins[30:20];
        else if (ins[30])            vt = {1'b0, ins[29:20]};
        else if (ins[29:25] == 5'd0) vt = r2[10:0];
        else                         return e;
        e.cfg   = 1'b1;
        e.vtype = vt;
        if (ins[31:30] == 2'b11)     avl = ins[19:15];
        else if (ins[19:15] != 5'd0) avl = r1;
        else if (ins[11:7] != 5'd0)  avl = 64'hFFFF_FFFF;
        else                         avl = vc;
        sew     = 8 << vt[5:3];
        lm      = int'(vt[2:0]);
        e.legal = (vt[5:3] <= 3'd2) && (sew <= ELEN) && (vt[10:8] == 3'd0);
        if (lm <= 3) begin
            vlmax = longint'(VLEN * (1 << lm) / sew);
        end else begin
            den = 1 << (8 - lm);
`ifdef VCFG_FRAC_LMUL_EN
            e.legal = e.legal && (lm != 4) && (sew * den <= ELEN);
`else
            e.legal = 1'b0;
`endif
            vlmax = longint'(VLEN / (sew * den));
        end
        if (e.legal) e.vl = (avl < vlmax) ? avl[31:0] : vlmax[31:0];
        return e;
    endfunction

    exp_t        m_exp    = '0;
    int          m_wait   = 0;    // edges left before the controller is free again
    logic        m_commit = 1'b0; // current cycle is the completion cycle of m_exp
    logic        m_vill   = 1'b0;
    int unsigned n_accept = 0;

    always @(posedge clk) begin
        if (!nrst) begin
            m_wait   <= 0;
            m_commit <= 1'b0;
            m_vill   <= 1'b0;
        end else if (m_wait != 0) begin
            m_wait   <= m_wait - 1;
            m_commit <= (m_wait == 2);
            if (m_wait == 2 && m_exp.cfg) m_vill <= !m_exp.legal;
        end else begin
            m_commit <= 1'b0;
            if (cfg_valid) begin
                m_exp    <= predict(cfg_instr, rs1_data, rs2_data, vl_cur);
                m_wait   <= 2;
                n_accept <= n_accept + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    int   n_done = 0;
    int   n_wr   = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cfg_ready", 32'(cfg_ready), 32'(nrst && m_wait == 0));
            check("csr_wr_en", 32'(csr_wr_en), 32'(m_commit && m_exp.cfg));
            check("cfg_done",  32'(cfg_done),  32'(m_commit));
            check("rd_we",     32'(rd_we),     32'(m_commit && m_exp.cfg && m_exp.rd != 5'd0));
            check("vill",      32'(vill),      32'(m_vill));
            if (m_commit && m_exp.cfg) begin
                check("csr_vl",    csr_vl,    m_exp.vl);
                check("csr_vtype", csr_vtype, m_exp.legal ? {1'b0, m_exp.vtype, 20'd0} : 32'd0);
            end
            if (m_commit && m_exp.cfg && m_exp.rd != 5'd0) begin
                check("rd_addr", 32'(rd_addr), 32'(m_exp.rd));
                check("rd_data", rd_data,      m_exp.vl);
            end
        end
        if (cfg_done === 1'b1)  n_done++;
        if (csr_wr_en === 1'b1) n_wr++;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                                input logic [10:0] vt);
        return {1'b0, vt, rs1, 3'b111, rd, OPC_V};
    endfunction

    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                                 input logic [9:0] vt);
        return {2'b11, vt, uimm, 3'b111, rd, OPC_V};
    endfunction

    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, OPC_V};
    endfunction

    // Offers one instruction, scrambles the inputs after acceptance, returns mid-way through completion.
    task automatic issue(input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] vc);
        int unsigned start;
        int          guard;
        @(negedge clk);
        #1;
        cfg_instr = ins;
        rs1_data  = r1;
        rs2_data  = r2;
        vl_cur    = vc;
        cfg_valid = 1'b1;
        start     = n_accept;
        guard     = 0;
        while (n_accept == start && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("accept", n_accept - start, 32'd1);
        cfg_valid = 1'b0;
        cfg_instr = 32'hFFFF_FFFF;
        rs1_data  = ~r1;
        rs2_data  = ~r2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_commit(input string name, input logic wr, input logic [31:0] vl_w,
                                 input logic [31:0] vt_w, input logic we, input logic [4:0] addr,
                                 input logic ill);
        check({name, " csr_wr_en"}, 32'(csr_wr_en), 32'(wr));
        check({name, " cfg_done"},  32'(cfg_done),  32'd1);
        check({name, " rd_we"},     32'(rd_we),     32'(we));
        check({name, " vill"},      32'(vill),      32'(ill));
        if (wr) begin
            check({name, " csr_vl"},    csr_vl,    vl_w);
            check({name, " csr_vtype"}, csr_vtype, vt_w);
        end
        if (we) begin
            check({name, " rd_addr"}, 32'(rd_addr), 32'(addr));
            check({name, " rd_data"}, rd_data,      vl_w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned start;
        int          base_wr;
        int          base_done;

        nrst      = 1'b0;
        cfg_valid = 1'b0;
        cfg_instr = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        vl_cur    = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset cfg_ready", 32'(cfg_ready), 32'd0);
        check("reset csr_vl",    csr_vl,         32'd0);
        check("reset csr_vtype", csr_vtype,      32'd0);
        check("reset rd_addr",   32'(rd_addr),   32'd0);
        check("reset rd_data",   rd_data,        32'd0);
        check("reset vill",      32'(vill),      32'd0);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        check("post-reset cfg_ready", 32'(cfg_ready), 32'd1);

        // vsetvli x5,x6,e32,m1 with AVL 20
        issue(enc_vsetvli(5'd5, 5'd6, 11'h010), 32'd20, 32'd0, 32'd0);
        expect_commit("vsetvli e32m1", 1'b1, 32'd16, 32'h0100_0000, 1'b1, 5'd5, 1'b0);
        check("model pin vsetvli vl", m_exp.vl, 32'd16);

        // vsetivli x1,5,e8,m2
        issue(enc_vsetivli(5'd1, 5'd5, 10'h001), 32'd0, 32'd0, 32'd0);
        expect_commit("vsetivli e8m2", 1'b1, 32'd5, 32'h0010_0000, 1'b1, 5'd1, 1'b0);

        // vsetvl x7,x0,x9 with e16 m4: rs1 == x0, rd != x0 -> VLMAX
        issue(enc_vsetvl(5'd7, 5'd0, 5'd9), 32'd0, 32'h0000_000A, 32'd0);
        expect_commit("vsetvl e16m4", 1'b1, 32'd128, 32'h00A0_0000, 1'b1, 5'd7, 1'b0);
        check("model pin vsetvl vl", m_exp.vl, 32'd128);

        // Same with rd == x0: keep vl_cur
        issue(enc_vsetvl(5'd0, 5'd0, 5'd9), 32'd0, 32'h0000_000A, 32'd40);
        expect_commit("vsetvl keep vl", 1'b1, 32'd40, 32'h00A0_0000, 1'b0, 5'd0, 1'b0);

        // vlmul 5 (1/8) is illegal in every build
        issue(enc_vsetvl(5'd3, 5'd4, 5'd5), 32'd99, 32'h0000_000D, 32'd0);
        expect_commit("vsetvl mf8 illegal", 1'b1, 32'd0, 32'd0, 1'b1, 5'd3, 1'b1);

        // Non-config instructions leave vill alone and write nothing
        issue(32'h0000_0033, 32'd1, 32'd2, 32'd0);
        expect_commit("non-config add", 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        issue({7'b1000001, 5'd1, 5'd2, 3'b111, 5'd3, OPC_V}, 32'd1, 32'd2, 32'd0);
        expect_commit("non-config 10xx", 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);

        // e8 m8 with AVL above VLMAX clears vill
        issue(enc_vsetvli(5'd2, 5'd3, 11'h003), 32'd1000, 32'd0, 32'd0);
        expect_commit("vsetvli e8m8 clamp", 1'b1, 32'd512, 32'h0030_0000, 1'b1, 5'd2, 1'b0);

        // SEW=64 is illegal at ELEN=32
        issue(enc_vsetvli(5'd2, 5'd3, 11'h018), 32'd10, 32'd0, 32'd0);
        expect_commit("vsetvli e64 illegal", 1'b1, 32'd0, 32'd0, 1'b1, 5'd2, 1'b1);
        check("model pin e64 legal", 32'(m_exp.legal), 32'd0);

        // Following legal vsetvli with vta/vma set clears vill
        issue(enc_vsetvli(5'd8, 5'd9, 11'h0D0), 32'd50, 32'd0, 32'd0);
        expect_commit("vsetvli ta ma", 1'b1, 32'd16, 32'h0D00_0000, 1'b1, 5'd8, 1'b0);

        // Reserved vtype bit set
        issue(enc_vsetvli(5'd4, 5'd5, 11'h110), 32'd3, 32'd0, 32'd0);
        expect_commit("vsetvli reserved bit", 1'b1, 32'd0, 32'd0, 1'b1, 5'd4, 1'b1);

        // rd == x0, rs1 == x0: AVL = vl_cur, below and above VLMAX
        issue(enc_vsetvli(5'd0, 5'd0, 11'h010), 32'd0, 32'd0, 32'd7);
        expect_commit("vsetvli keep 7", 1'b1, 32'd7, 32'h0100_0000, 1'b0, 5'd0, 1'b0);
        issue(enc_vsetvli(5'd0, 5'd0, 11'h010), 32'd0, 32'd0, 32'd100);
        expect_commit("vsetvli keep 100", 1'b1, 32'd16, 32'h0100_0000, 1'b0, 5'd0, 1'b0);

        // AVL = 0
        issue(enc_vsetvli(5'd6, 5'd7, 11'h010), 32'd0, 32'd0, 32'd0);
        expect_commit("vsetvli avl0", 1'b1, 32'd0, 32'h0100_0000, 1'b1, 5'd6, 1'b0);

        // e8 mf4, rs1 == x0, rd == x1
        issue(enc_vsetvli(5'd1, 5'd0, 11'h006), 32'd0, 32'd0, 32'd0);
`ifdef VCFG_FRAC_LMUL_EN
        expect_commit("vsetvli e8mf4", 1'b1, 32'd16, 32'h0060_0000, 1'b1, 5'd1, 1'b0);
`else
        expect_commit("vsetvli e8mf4", 1'b1, 32'd0, 32'd0, 1'b1, 5'd1, 1'b1);
`endif

        // Reset during CALC drops the instruction
        @(negedge clk);
        #1;
        cfg_instr = enc_vsetvli(5'd5, 5'd6, 11'h010);
        rs1_data  = 32'd20;
        cfg_valid = 1'b1;
        start     = n_accept;
        base_wr   = n_wr;
        base_done = n_done;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check("reset-in-calc accept", n_accept - start, 32'd1);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset-in-calc csr writes", 32'(n_wr - base_wr),     32'd0);
        check("reset-in-calc done",       32'(n_done - base_done), 32'd0);
        check("reset-in-calc cfg_ready",  32'(cfg_ready),          32'd1);
        check("reset-in-calc vill",       32'(vill),               32'd0);

        // cfg_valid held high: accepts every third edge
        cfg_instr = enc_vsetvli(5'd1, 5'd2, 11'h010);
        rs1_data  = 32'd4;
        vl_cur    = 32'd0;
        start     = n_accept;
        base_done = n_done;
        cfg_valid = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("back-to-back accepts", n_accept - start,            32'd3);
        check("back-to-back done",    32'(n_done - base_done),     32'd3);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
